// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit: req/ack data bus, lane steering, load extension
module mem_stage_lsu #(
    parameter int unsigned ADDR_LIMIT = 9184,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        stall,
    output logic        resp_valid,
    output logic        resp_load,
    output logic [4:0]  resp_rd,
    output logic [63:0] resp_data,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_be,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE,
        S_ERR
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] cnt_q;
    logic          we_q;
    logic          load_q;
    logic [4:0]    rd_q;
    logic [31:0]   addr_q;
    logic [7:0]    be_q;
    logic [63:0]   wdata_q;
    logic [2:0]    off_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [63:0]   rdata_q;

    logic          accept;
    logic [2:0]    amask;
    logic [7:0]    lane_mask;
    logic [32:0]   last_byte;
    logic          illegal;
    logic [63:0]   rd_shifted;
    logic [63:0]   rd_fmt;

    assign accept = req_valid & (req_load | req_store);

    // amask is both the alignment mask and (size in bytes - 1)
    always_comb begin
        amask     = 3'b000;
        lane_mask = 8'h01;
        case (req_func3[1:0])
            2'd0: begin amask = 3'b000; lane_mask = 8'h01; end
            2'd1: begin amask = 3'b001; lane_mask = 8'h03; end
            2'd2: begin amask = 3'b011; lane_mask = 8'h0F; end
            default: begin amask = 3'b111; lane_mask = 8'hFF; end
        endcase
    end

    assign last_byte = {1'b0, req_addr} + {30'd0, amask};
    assign illegal   = ((req_addr[2:0] & amask) != 3'b000)
                     | (last_byte > 33'(ADDR_LIMIT))
                     | (req_load & req_store);

    assign rd_shifted = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        rd_fmt = rd_shifted;
        case (size_q)
            2'd0: rd_fmt = uns_q ? {56'd0, rd_shifted[7:0]}  : {{56{rd_shifted[7]}},  rd_shifted[7:0]};
            2'd1: rd_fmt = uns_q ? {48'd0, rd_shifted[15:0]} : {{48{rd_shifted[15]}}, rd_shifted[15:0]};
            2'd2: rd_fmt = uns_q ? {32'd0, rd_shifted[31:0]} : {{32{rd_shifted[31]}}, rd_shifted[31:0]};
            default: rd_fmt = rd_shifted;
        endcase
    end

    // an ack in the final allowed cycle still completes normally
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = illegal ? S_ERR : S_BUSY;
            S_BUSY: begin
                if (mem_ack)
                    state_d = S_DONE;
                else if (cnt_q == CW'(TIMEOUT - 1))
                    state_d = S_ERR;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            load_q  <= 1'b0;
            rd_q    <= 5'd0;
            addr_q  <= 32'd0;
            be_q    <= 8'd0;
            wdata_q <= 64'd0;
            off_q   <= 3'd0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            rdata_q <= 64'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_BUSY && state_d == S_BUSY)
                cnt_q <= cnt_q + 1'b1;
            else
                cnt_q <= '0;
            if (state_q == S_IDLE && accept) begin
                we_q    <= req_store;
                load_q  <= req_load;
                rd_q    <= req_rd;
                addr_q  <= {req_addr[31:3], 3'b000};
                be_q    <= lane_mask << req_addr[2:0];
                wdata_q <= req_store ? (req_wdata << {req_addr[2:0], 3'b000}) : 64'd0;
                off_q   <= req_addr[2:0];
                size_q  <= req_func3[1:0];
                uns_q   <= req_func3[2];
            end
            if (state_q == S_BUSY && mem_ack)
                rdata_q <= rd_fmt;
        end
    end

    assign stall      = (state_q == S_BUSY) || (state_q == S_IDLE && accept);
    assign mem_req    = (state_q == S_BUSY);
    assign mem_we     = mem_req & we_q;
    assign mem_addr   = mem_req ? addr_q : 32'd0;
    assign mem_be     = mem_req ? be_q : 8'd0;
    assign mem_wdata  = mem_req ? wdata_q : 64'd0;
    assign resp_valid = (state_q == S_DONE);
    assign resp_load  = resp_valid & load_q;
    assign resp_rd    = resp_load ? rd_q : 5'd0;
    assign resp_data  = resp_load ? rdata_q : 64'd0;
    assign fault      = (state_q == S_ERR);

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the MEM stage of the 5-stage RV64 pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB register.
- Turns one load/store request into a req/ack transaction on a 64-bit data-memory bus, with byte enables for stores and load-data alignment plus sign/zero extension.
- Holds the pipeline stalled until the memory access completes, faults or times out.

Parameters:
ADDR_LIMIT, 9184, highest legal byte address; any access whose last byte exceeds it faults.
TIMEOUT, 64, max cycles mem_req may stay high without mem_ack before the access aborts (must be ≥2).

Ports:
clk  input  1  clock
rst  input  1  reset
req_valid  input  1  EX/MEM holds a valid memory instruction
req_load  input  1  instruction is a load
req_store  input  1  instruction is a store
req_func3  input  3  RISC-V funct3; [1:0] size (0=B,1=H,2=W,3=D), [2] unsigned load
req_addr  input  32  byte address (EX result)
req_wdata  input  64  store data (rs2)
req_rd  input  5  load destination register
stall  output  1  freeze IF..EX/MEM registers while high
resp_valid  output  1  one-cycle pulse; access completed
resp_load  output  1  completed access was a load
resp_rd  output  5  rd of completed load (0 for stores)
resp_data  output  64  formatted load data (0 for stores)
fault  output  1  one-cycle pulse; misaligned, out-of-range, conflicting or timed-out access
mem_req  output  1  bus request, held until mem_ack
mem_we  output  1  1 = write
mem_addr  output  32  doubleword-aligned address (req_addr & ~7)
mem_be  output  8  byte enables
mem_wdata  output  64  lane-shifted store data
mem_ack  input  1  bus completion; mem_rdata valid on the same cycle
mem_rdata  input  64  read data

Behaviour:
- Reset: rst synchronous, active-high; clk rising edge. All outputs 0; FSM to IDLE; timeout counter 0.
- FSM states: IDLE, BUSY, DONE, ERR.
- Request accepted in IDLE when req_valid & (req_load | req_store).
  - stall is combinational: high in the acceptance cycle.
  - Request fields are registered at the acceptance edge.
- Legality check, evaluated in IDLE on the raw inputs. The access is illegal if any of:
  - req_addr is not a multiple of 2^size;
  - req_addr + 2^size − 1 > ADDR_LIMIT;
  - req_load & req_store are both set.
- Illegal access: IDLE→ERR. In ERR, fault=1 and stall=0 for one cycle, then ERR→IDLE. No mem_req is ever issued.
- Legal access: IDLE→BUSY.
  - mem_req=1 and mem_we=req_store from the next cycle.
  - mem_addr, mem_be and mem_wdata are stable until the ack.
- Store lanes:
  - mem_be = ((1<<2^size)−1) << addr[2:0].
  - mem_wdata = req_wdata << (8·addr[2:0]).
- Load lanes: mem_be as for stores; mem_wdata=0.
- BUSY with mem_ack=1: drop mem_req at that edge; BUSY→DONE.
  - Loads: capture mem_rdata >> (8·addr[2:0]), truncate to the access size, then extend (func3[2]=1 zero-extend, else sign-extend).
- DONE, one cycle:
  - resp_valid=1, stall=0.
  - resp_load, resp_rd and resp_data are valid.
  - DONE→IDLE.
  - A new request presented in DONE is not sampled; it is accepted in the following IDLE cycle.
- Timeout:
  - The counter increments each BUSY cycle without an ack.
  - At count==TIMEOUT−1 with no ack: BUSY→ERR, mem_req drops, fault pulses, no resp_valid.
  - An ack on that same cycle wins; it is a normal completion.
- stall summary: high during the IDLE acceptance cycle and every BUSY cycle; low in IDLE (no request), DONE and ERR.
  - Access latency = ack cycle + 1.
- mem_ack outside BUSY is ignored. req_* inputs while not in IDLE are ignored.
- Reset mid-transaction: mem_req=0 and stall=0 after the reset edge; a late mem_ack produces no resp_valid.
- Non-memory instructions (req_load=req_store=0): no stall, no outputs.

Test Plan:
- Reset: assert rst 2 cycles during BUSY → next cycle mem_req=0, stall=0, resp_valid=0; later mem_ack ignored.
- SD at 0x100, wdata=0x1122334455667788, ack after 3 cycles → mem_addr=0x100, mem_be=0xFF, mem_we=1; stall high 4 cycles; resp_valid with resp_load=0.
- SB at 0x103, wdata=0xAB → mem_addr=0x100, mem_be=0x08, mem_wdata=0x00000000AB000000.
- LH at 0x106, rdata=0x8001_0000_0000_0000 → resp_data=0xFFFFFFFFFFFF8001. LHU at the same address → 0x0000000000008001. resp_rd equals req_rd.
- Illegal accesses → fault pulse one cycle later, no mem_req, stall high only in the acceptance cycle:
  - LW at 0x102;
  - SD at 0x23E0 (last byte 9191 > 9184);
  - load and store both set.
- Timeout: LD with mem_ack held 0 and TIMEOUT=64 → mem_req high 64 cycles, then fault pulse, stall drops, no resp_valid. Repeat with ack on the 64th cycle → normal completion.
